// File: rtl/ysyx_23060061_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
// The YSYX_23060061_ARB_RR_EN macro selects round-robin arbitration in ysyx_23060061_arb_pick.
package ysyx_23060061_pkg;

  localparam int XLEN   = 32;
  localparam int MASK_W = XLEN / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  function automatic logic other_owner(input logic owner);
    return (owner == OWNER_IFU) ? OWNER_LSU : OWNER_IFU;
  endfunction

endpackage

// File: rtl/ysyx_23060061_arb_pick.sv
// Combinational winner selection between IFU and LSU requesters.
// YSYX_23060061_ARB_RR_EN: contention goes to the requester that did not win last; otherwise LSU wins.
module ysyx_23060061_arb_pick
  import ysyx_23060061_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic last_owner,
  output logic grant,
  output logic owner
);

  always_comb begin
    grant = ifu_valid | lsu_valid;
    owner = OWNER_IFU;
    if (ifu_valid && lsu_valid) begin
`ifdef YSYX_23060061_ARB_RR_EN
      owner = other_owner(last_owner);
`else
      owner = OWNER_LSU;
`endif
    end else if (lsu_valid) begin
      owner = OWNER_LSU;
    end
  end

`ifndef YSYX_23060061_ARB_RR_EN
  // Fixed priority never consults history; keep the port for a uniform interface.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/ysyx_23060061_mem_arbiter.sv
// Two-requester (IFU read-only, LSU read/write) arbiter onto a single-outstanding memory port.
// Build with YSYX_23060061_ARB_RR_EN for round-robin, default is LSU fixed priority.
module ysyx_23060061_mem_arbiter
  import ysyx_23060061_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;

  logic grant, pick_owner;
  logic accept, resp_fire;

  ysyx_23060061_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_owner (last_owner_q),
    .grant      (grant),
    .owner      (pick_owner)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    accept       = (state_q == ST_IDLE) && grant;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_ISSUE;
          owner_d      = pick_owner;
          last_owner_d = pick_owner;
          if (pick_owner == OWNER_LSU) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
          end else begin
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      ST_ISSUE: if (mem_req_ready)  state_d = ST_WAIT;
      ST_WAIT:  if (mem_resp_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_IFU;
      last_owner_q <= OWNER_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

  // Outputs are forced low while rst is high, including the cycle before the first reset edge.
  assign resp_fire      = !rst && (state_q == ST_WAIT) && mem_resp_valid;

  assign ifu_req_ready  = !rst && accept && (pick_owner == OWNER_IFU);
  assign lsu_req_ready  = !rst && accept && (pick_owner == OWNER_LSU);

  assign ifu_resp_valid = resp_fire && (owner_q == OWNER_IFU);
  assign lsu_resp_valid = resp_fire && (owner_q == OWNER_LSU);
  assign ifu_rdata      = ifu_resp_valid ? mem_resp_data : '0;
  assign lsu_rdata      = lsu_resp_valid ? mem_resp_data : '0;

  assign mem_req_valid  = !rst && (state_q == ST_ISSUE);
  assign mem_addr       = rst ? '0   : addr_q;
  assign mem_wen        = rst ? 1'b0 : wen_q;
  assign mem_wdata      = rst ? '0   : wdata_q;
  assign mem_wmask      = rst ? '0   : wmask_q;

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: directed scenarios plus a randomized transaction model.
module tb_ysyx_23060061_mem_arbiter;

  logic        clk, rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_resp_data;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int errors = 0;
  bit model_last = 1'b0;   // 0 = IFU won most recently, 1 = LSU

  ysyx_23060061_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Arbitration rule: 1 means the LSU should win.
  function automatic bit spec_winner(bit i, bit l, bit last);
    if (i && l) begin
`ifdef YSYX_23060061_ARB_RR_EN
      return !last;
`else
      return 1'b1;
`endif
    end
    return l;
  endfunction

  // Completes whatever access is in flight (stimulus only, bounded).
  task automatic drain();
    bit done = 1'b0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      settle();
      if (ifu_resp_valid || lsu_resp_valid) done = 1'b1;
      tick();
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout got no response want response within 20 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0000; lsu_addr = 32'h8000_2000;
    lsu_wen = 1'b1; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, ifu_rdata, lsu_rdata,
           mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d got rdy=%b%b rsp=%b%b mreq=%b maddr=%h want all 0",
                 c, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_addr);
      end
      tick();
    end
    rst = 1'b0;
    lsu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    model_last = 1'b0;
    settle();
    checks++;
    if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_accept got ifu=%b lsu=%b want ifu=1 lsu=0", ifu_req_ready, lsu_req_ready);
    end
    tick();
    ifu_req_valid = 1'b0;
    drain();
  endtask

  task automatic test_ifu_read();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    settle();
    checks++;
    if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ifu_accept got ifu=%b lsu=%b want ifu=1 lsu=0", ifu_req_ready, lsu_req_ready);
    end
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    settle();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0 || mem_wmask !== 4'h0) begin
      errors++;
      $display("FAIL ifu_issue got v=%b a=%h w=%b m=%h want v=1 a=80000000 w=0 m=0",
               mem_req_valid, mem_addr, mem_wen, mem_wmask);
    end
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0413;
    settle();
    checks++;
    if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || lsu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ifu_resp got v=%b d=%h lsu_v=%b want v=1 d=00000413 lsu_v=0",
               ifu_resp_valid, ifu_rdata, lsu_resp_valid);
    end
    tick();
    mem_resp_valid = 1'b0;
    settle();
    checks++;
    if (ifu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL ifu_resp_pulse got rsp=%b mreq=%b want 0 0", ifu_resp_valid, mem_req_valid);
    end
    model_last = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000;
    lsu_wen = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    settle();
    checks++;
    if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL simul_lsu_first got ifu=%b lsu=%b want ifu=0 lsu=1", ifu_req_ready, lsu_req_ready);
    end
    model_last = 1'b1;
    tick();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    settle();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_1000 || mem_wen !== 1'b1 ||
        mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'hF || ifu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL simul_issue got v=%b a=%h w=%b d=%h m=%h irdy=%b want 1 80001000 1 deadbeef f 0",
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready);
    end
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = $urandom;
    settle();
    checks++;
    if (lsu_resp_valid !== 1'b1 || ifu_resp_valid !== 1'b0 || ifu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL simul_resp got lsu_v=%b ifu_v=%b irdy=%b want 1 0 0",
               lsu_resp_valid, ifu_resp_valid, ifu_req_ready);
    end
    tick();
    mem_resp_valid = 1'b0;
    settle();
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_ifu_t3 got ifu_rdy=%b want 1", ifu_req_ready);
    end
    model_last = 1'b0;
    tick();
    ifu_req_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    int grants = 0;
    int last_cyc = -1;
    bit exp;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = $urandom; lsu_addr = $urandom; lsu_wen = 1'b0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = $urandom;
    for (int c = 0; c < 40 && grants < 6; c++) begin
      settle();
      if (ifu_req_ready || lsu_req_ready) begin
        exp = spec_winner(1'b1, 1'b1, model_last);
        checks++;
        if (lsu_req_ready !== exp || ifu_req_ready !== !exp) begin
          errors++;
          $display("FAIL b2b_grant n=%0d got ifu=%b lsu=%b want lsu=%b", grants, ifu_req_ready, lsu_req_ready, exp);
        end
        if (last_cyc >= 0) begin
          checks++;
          if (c - last_cyc != 3) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want 3", c - last_cyc);
          end
        end
        model_last = exp;
        last_cyc = c;
        grants++;
      end
      tick();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    checks++;
    if (grants != 6) begin
      errors++;
      $display("FAIL b2b_timeout got %0d grants want 6", grants);
    end
    drain();
  endtask

  task automatic test_stall();
    bit win;
    logic [31:0] e_addr, e_wdata;
    logic e_wen;
    logic [3:0] e_wmask;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = $urandom; lsu_addr = $urandom;
    lsu_wen = 1'b1; lsu_wdata = $urandom; lsu_wmask = 4'($urandom_range(1, 15));
    win = spec_winner(1'b1, 1'b1, model_last);
    e_addr = win ? lsu_addr : ifu_addr;
    e_wen = win; e_wdata = lsu_wdata; e_wmask = win ? lsu_wmask : 4'h0;
    settle();
    checks++;
    if (lsu_req_ready !== win || ifu_req_ready !== !win) begin
      errors++;
      $display("FAIL stall_accept got ifu=%b lsu=%b want lsu=%b", ifu_req_ready, lsu_req_ready, win);
    end
    model_last = win;
    tick();
    if (win) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== e_addr || mem_wen !== e_wen || mem_wmask !== e_wmask ||
          (e_wen && mem_wdata !== e_wdata) || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got v=%b a=%h w=%b d=%h m=%h rdy=%b%b want 1 %h %b %h %h 00",
                 c, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready, lsu_req_ready,
                 e_addr, e_wen, e_wdata, e_wmask);
      end
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = $urandom;
    settle();
    checks++;
    if (lsu_resp_valid !== win || ifu_resp_valid !== !win) begin
      errors++;
      $display("FAIL stall_resp got ifu=%b lsu=%b want lsu=%b", ifu_resp_valid, lsu_resp_valid, win);
    end
    tick();
    mem_resp_valid = 1'b0;
    settle();
    checks++;
    if (lsu_req_ready !== !win || ifu_req_ready !== win) begin
      errors++;
      $display("FAIL stall_other got ifu=%b lsu=%b want lsu=%b", ifu_req_ready, lsu_req_ready, !win);
    end
    model_last = !win;
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_in_wait();
    lsu_req_valid = 1'b1; lsu_addr = $urandom; lsu_wen = 1'b0;
    settle();
    checks++;
    if (lsu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_accept got lsu=%b want 1", lsu_req_ready);
    end
    tick();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; rst = 1'b1;
    settle();
    checks++;
    if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_in_rst got rsp=%b%b mreq=%b want 000", ifu_resp_valid, lsu_resp_valid, mem_req_valid);
    end
    tick();
    rst = 1'b0; model_last = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = $urandom;
    settle();
    checks++;
    if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_ignore got rsp=%b%b mreq=%b want 000", ifu_resp_valid, lsu_resp_valid, mem_req_valid);
    end
    tick();
    ifu_req_valid = 1'b1; ifu_addr = $urandom;
    settle();
    checks++;
    if (ifu_req_ready !== 1'b1 || ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_idle got ifu_rdy=%b rsp=%b%b want 1 00", ifu_req_ready, ifu_resp_valid, lsu_resp_valid);
    end
    tick();
    ifu_req_valid = 1'b0;
    settle();
    checks++;
    if (mem_req_valid !== 1'b1 || ifu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL issue_ignores_resp got mreq=%b ifu_rsp=%b want 1 0", mem_req_valid, ifu_resp_valid);
    end
    tick();
    mem_resp_valid = 1'b0;
    drain();
  endtask

  task automatic test_random();
    bit ifu_p = 0, lsu_p = 0, busy = 0, issued = 0, own = 0, acc, win;
    logic [31:0] e_addr = '0, e_wdata = '0;
    logic e_wen = 1'b0;
    logic [3:0] e_wmask = '0;
    for (int c = 0; c < 600; c++) begin
      if (!ifu_p && $urandom_range(0, 2) == 0) begin
        ifu_p = 1; ifu_addr = $urandom;
      end
      if (!lsu_p && $urandom_range(0, 2) == 0) begin
        lsu_p = 1; lsu_addr = $urandom; lsu_wen = 1'($urandom);
        lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
      end
      ifu_req_valid = ifu_p; lsu_req_valid = lsu_p;
      mem_req_ready = 1'($urandom);
      mem_resp_valid = ($urandom_range(0, 2) == 0);
      mem_resp_data = $urandom;
      settle();
      acc = !busy && (ifu_p || lsu_p);
      win = spec_winner(ifu_p, lsu_p, model_last);
      checks++;
      if (ifu_req_ready !== (acc && !win) || lsu_req_ready !== (acc && win)) begin
        errors++;
        $display("FAIL rnd_ready cyc %0d got ifu=%b lsu=%b want ifu=%b lsu=%b",
                 c, ifu_req_ready, lsu_req_ready, acc && !win, acc && win);
      end
      checks++;
      if (mem_req_valid !== (busy && !issued) ||
          (busy && !issued && (mem_addr !== e_addr || mem_wen !== e_wen || mem_wmask !== e_wmask ||
                               (e_wen && mem_wdata !== e_wdata)))) begin
        errors++;
        $display("FAIL rnd_memreq cyc %0d got v=%b a=%h w=%b d=%h m=%h want v=%b a=%h w=%b d=%h m=%h",
                 c, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
                 busy && !issued, e_addr, e_wen, e_wdata, e_wmask);
      end
      checks++;
      if (ifu_resp_valid !== (busy && issued && mem_resp_valid && !own) ||
          lsu_resp_valid !== (busy && issued && mem_resp_valid && own) ||
          (ifu_resp_valid && ifu_rdata !== mem_resp_data) ||
          (lsu_resp_valid && !e_wen && lsu_rdata !== mem_resp_data)) begin
        errors++;
        $display("FAIL rnd_resp cyc %0d got ifu=%b/%h lsu=%b/%h want ifu=%b lsu=%b data=%h",
                 c, ifu_resp_valid, ifu_rdata, lsu_resp_valid, lsu_rdata,
                 busy && issued && mem_resp_valid && !own, busy && issued && mem_resp_valid && own, mem_resp_data);
      end
      if (acc) begin
        busy = 1; issued = 0; own = win; model_last = win;
        if (win) begin
          e_addr = lsu_addr; e_wen = lsu_wen; e_wdata = lsu_wdata; e_wmask = lsu_wmask; lsu_p = 0;
        end else begin
          e_addr = ifu_addr; e_wen = 1'b0; e_wdata = '0; e_wmask = 4'h0; ifu_p = 0;
        end
      end else if (busy && !issued && mem_req_ready) begin
        issued = 1;
      end else if (busy && issued && mem_resp_valid) begin
        busy = 0;
      end
      tick();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    if (busy) drain();
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_simultaneous();
    test_back_to_back();
    test_stall();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060061_mem_arbiter.md
YSYX_23060061_MEM_ARBITER -- requirements
Module: ysyx_23060061_mem_arbiter

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have ports ifu_req_valid/lsu_req_valid  input  1 each  requester has a memory access pending.
REQ-004 SHALL have ports ifu_req_ready/lsu_req_ready  output  1 each  request accepted this cycle.
REQ-005 SHALL have ports ifu_addr/lsu_addr  input  32 each  byte address.
REQ-006 SHALL have ports lsu_wen  input  1, lsu_wdata  input  32, lsu_wmask  input  4  LSU write controls; the IFU path is read-only.
REQ-007 SHALL have ports ifu_resp_valid/lsu_resp_valid  output  1 each, ifu_rdata/lsu_rdata  output  32 each  one-cycle response pulse and read data.
REQ-008 SHALL have ports mem_req_valid  output  1, mem_req_ready  input  1, mem_addr  output  32, mem_wen  output  1, mem_wdata  output  32, mem_wmask  output  4  shared memory request channel.
REQ-009 SHALL have ports mem_resp_valid  input  1, mem_resp_data  input  32  shared memory response channel.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT; exactly one access SHALL be outstanding at any time.
REQ-011 In IDLE with at least one req_valid, SHALL select one winner, assert only that requester's req_ready combinationally in the same cycle, register its addr/wen/wdata/wmask (IFU: wen=0, wmask=0) and owner ID, and go to ISSUE.
REQ-012 In IDLE with no req_valid, SHALL assert no req_ready and stay in IDLE.
REQ-013 Req_ready SHALL be 0 in ISSUE and WAIT; requesters hold valid and fields stable until ready.
REQ-014 In ISSUE, SHALL drive mem_req_valid=1 with the registered fields; on mem_req_ready=1 go to WAIT, else stay in ISSUE with the fields held.
REQ-015 mem_req_valid SHALL be 0 in IDLE and WAIT.
REQ-016 In WAIT, on mem_resp_valid=1, SHALL assert the owner's resp_valid combinationally in the same cycle with rdata=mem_resp_data, keep the other resp_valid at 0, and go to IDLE.
REQ-017 Writes SHALL also complete via mem_resp_valid; the LSU receives resp_valid with don't-care rdata.
REQ-018 mem_resp_valid in IDLE or ISSUE SHALL be ignored: no resp_valid, no state change.
REQ-019 Minimum accept-to-next-accept spacing SHALL be 3 cycles: accept at T, issue at T+1, response at T+2, next accept at T+3.
REQ-020 ifu_rdata/lsu_rdata SHALL equal mem_resp_data whenever the matching resp_valid is 1; otherwise their value is don't-care.
REQ-021 SHALL maintain a last_owner register, updated on every accept.

Reset
REQ-022 While rst=1, SHALL set state=IDLE, last_owner=IFU, registered fields=0, and drive every output to 0.
REQ-023 Reset asserted in ISSUE or WAIT SHALL abandon the access; a later mem_resp_valid SHALL be ignored per REQ-018.
REQ-024 In the first cycle after rst deasserts, SHALL be able to accept a request.

Configuration
REQ-025 With macro YSYX_23060061_ARB_RR_EN defined, SHALL arbitrate round-robin: on simultaneous requests the requester that is not last_owner wins.
REQ-026 Without YSYX_23060061_ARB_RR_EN, SHALL use fixed priority: on simultaneous requests LSU wins; last_owner is still maintained.

Structure
REQ-027 SHALL place the FSM state enum, owner ID encoding (IFU=0, LSU=1) and the 32-bit address/data width constants in the shared package ysyx_23060061_pkg.
REQ-028 SHALL contain a single sub-module, ysyx_23060061_arb_pick: a combinational winner selector with inputs both valids and last_owner, and outputs grant and owner ID.

Verification
REQ-029 Reset: hold rst=1 with both requests valid -> all outputs 0; after release, IFU read 0x80000000 alone is accepted in the first cycle.
REQ-030 IFU read 0x80000000, mem_req_ready=1, mem_resp_data=0x00000413 one cycle later -> ifu_resp_valid pulse with ifu_rdata=0x00000413; lsu_resp_valid stays 0.
REQ-031 Simultaneous IFU read 0x80000004 and LSU write 0x80001000/0xDEADBEEF/0xF -> LSU first in both builds; after completion IFU is accepted at exactly T+3.
REQ-032 Both requesters continuously valid, RR build -> grants alternate IFU/LSU; non-RR build -> LSU granted every time.
REQ-033 mem_req_ready held low for 5 cycles in ISSUE -> mem_req_valid and fields stable; no req_ready asserted.
REQ-034 rst pulsed in WAIT, then mem_resp_valid=1 -> no resp_valid pulse; FSM in IDLE.
